stream_decoder: RTL

Backend-side parser for the 128-bit frontend word stream after the clock-domain-crossing FIFOs. It validates framing, classifies each word as time tag, single event or command, and tracks the latest time-tag period per module. Time tags are consumed here and never forwarded. Events leave stamped with their module's current coarse period; commands pass through unchanged. Integrity counters are exposed for the status registers.

---
 rtl/stream_pkg.sv | 26 ++
 rtl/module_time_table.sv | 37 +++
 rtl/stream_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared field positions, word classification and counter helper for the backend stream parser.
package stream_pkg;

   // Field bit positions within a 128-bit frontend word, MSB first
   localparam int unsigned FRAME_MSB    = 127;
   localparam int unsigned EV_FLAG_BIT  = 122;
   localparam int unsigned MOD_LSB      = 118;
   localparam int unsigned BLK_LSB      = 116;
   localparam int unsigned CMD_FLAG_BIT = 115;
   localparam int unsigned PERIOD_MSB   = 47;

   typedef enum logic [1:0] {
      WK_FRAME_ERR,
      WK_CMD,
      WK_EVENT,
      WK_TT
   } word_kind_e;

   // Increment that sticks at the all-ones value of a width-bit counter (width <= 64)
   function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
      logic [63:0] max_val;
      max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (value >= max_val) ? max_val : value + 64'd1;
   endfunction

endpackage

// File: rtl/module_time_table.sv
// Per-module synced flag and last time-tag period, one combinational read, one write port.
module module_time_table #(
   parameter int unsigned MODULE_ID_BITS = 4,
   parameter int unsigned PERIOD_BITS    = 48
) (
   input  logic                      clk_backend,
   input  logic                      rst,
   input  logic [MODULE_ID_BITS-1:0] rd_id,
   output logic                      rd_synced,
   output logic [PERIOD_BITS-1:0]    rd_last,
   input  logic                      we,
   input  logic [MODULE_ID_BITS-1:0] wr_id,
   input  logic [PERIOD_BITS-1:0]    wr_period
);

   localparam int unsigned DEPTH = 2 ** MODULE_ID_BITS;

   logic [DEPTH-1:0]       synced;
   logic [PERIOD_BITS-1:0] last [DEPTH];

   // Record the newest period and mark the module synced on every accepted time tag
   always_ff @(posedge clk_backend or posedge rst) begin
      if (rst) begin
         synced <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            last[i] <= '0;
         end
      end else if (we) begin
         synced[wr_id] <= 1'b1;
         last[wr_id]   <= wr_period;
      end
   end

   assign rd_synced = synced[rd_id];
   assign rd_last   = last[rd_id];

endmodule

// File: rtl/stream_decoder.sv
// Backend frontend-word parser: framing check, word classification, time-tag tracking,
// event period stamping, command pass-through and saturating integrity counters.
module stream_decoder
   import stream_pkg::*;
#(
   parameter int unsigned CRC_BITS       = 5,
   parameter int unsigned MODULE_ID_BITS = 4,
   parameter int unsigned PERIOD_BITS    = 48,
   parameter int unsigned DATA_BITS      = 128,
   parameter int unsigned COUNT_BITS     = 16
) (
   input  logic                      clk_backend,
   input  logic                      rst,
   input  logic [DATA_BITS-1:0]      in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [DATA_BITS-1:0]      ev_data,
   output logic [PERIOD_BITS-1:0]    ev_period,
   output logic                      ev_valid,
   input  logic                      ev_ready,
   output logic [DATA_BITS-1:0]      cmd_data,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic                      tt_update,
   output logic [MODULE_ID_BITS-1:0] tt_module,
   input  logic                      clr_counts,
   output logic [COUNT_BITS-1:0]     frame_err_count,
   output logic [COUNT_BITS-1:0]     tt_gap_count,
   output logic [COUNT_BITS-1:0]     unsynced_drop_count
);

   localparam logic [PERIOD_BITS-1:0] PERIOD_ONE = 1;

   logic [CRC_BITS-1:0]       word_framing;
   logic [MODULE_ID_BITS-1:0] word_module;
   logic [PERIOD_BITS-1:0]    word_period;
   word_kind_e                word_kind;
   logic                      accept;

   logic                      rd_synced;
   logic [PERIOD_BITS-1:0]    rd_last;
   logic [PERIOD_BITS-1:0]    next_expected;
   logic                      tt_we;
   logic                      tt_gap;
   logic                      ev_load;
   logic                      ev_drop;
   logic                      cmd_load;
   logic                      frame_err;

   logic [63:0]               frame_err_inc;
   logic [63:0]               tt_gap_inc;
   logic [63:0]               unsynced_drop_inc;
   logic [COUNT_BITS-1:0]     frame_err_d;
   logic [COUNT_BITS-1:0]     tt_gap_d;
   logic [COUNT_BITS-1:0]     unsynced_drop_d;

   assign word_framing = in_data[FRAME_MSB -: CRC_BITS];
   assign word_module  = in_data[MOD_LSB +: MODULE_ID_BITS];
   assign word_period  = in_data[PERIOD_MSB -: PERIOD_BITS];

   // Both output stages must be able to take a word; never a function of in_valid
   assign in_ready = ~rst & (~ev_valid | ev_ready) & (~cmd_valid | cmd_ready);
   assign accept   = in_valid & in_ready;

   // Classify the presented word: framing first, then command flag, then event flag
   always_comb begin
      word_kind = WK_TT;
      if (word_framing != '1) begin
         word_kind = WK_FRAME_ERR;
      end else if (in_data[CMD_FLAG_BIT]) begin
         word_kind = WK_CMD;
      end else if (in_data[EV_FLAG_BIT]) begin
         word_kind = WK_EVENT;
      end
   end

   module_time_table #(
      .MODULE_ID_BITS (MODULE_ID_BITS),
      .PERIOD_BITS    (PERIOD_BITS)
   ) u_time_table (
      .clk_backend (clk_backend),
      .rst         (rst),
      .rd_id       (word_module),
      .rd_synced   (rd_synced),
      .rd_last     (rd_last),
      .we          (tt_we),
      .wr_id       (word_module),
      .wr_period   (word_period)
   );

   // Period 0 is a frontend reset marker, so it never counts as a gap
   assign next_expected = rd_last + PERIOD_ONE;
   assign tt_we     = accept & (word_kind == WK_TT);
   assign tt_gap    = tt_we & rd_synced & (word_period != next_expected) & (word_period != '0);
   assign ev_load   = accept & (word_kind == WK_EVENT) & rd_synced;
   assign ev_drop   = accept & (word_kind == WK_EVENT) & ~rd_synced;
   assign cmd_load  = accept & (word_kind == WK_CMD);
   assign frame_err = accept & (word_kind == WK_FRAME_ERR);

   // Saturating counter next-state; a clear wins over a coincident increment
   always_comb begin
      frame_err_inc     = sat_inc(64'(frame_err_count), COUNT_BITS);
      tt_gap_inc        = sat_inc(64'(tt_gap_count), COUNT_BITS);
      unsynced_drop_inc = sat_inc(64'(unsynced_drop_count), COUNT_BITS);
      frame_err_d       = frame_err_count;
      tt_gap_d          = tt_gap_count;
      unsynced_drop_d   = unsynced_drop_count;
      if (frame_err) begin
         frame_err_d = frame_err_inc[COUNT_BITS-1:0];
      end
      if (tt_gap) begin
         tt_gap_d = tt_gap_inc[COUNT_BITS-1:0];
      end
      if (ev_drop) begin
         unsynced_drop_d = unsynced_drop_inc[COUNT_BITS-1:0];
      end
      if (clr_counts) begin
         frame_err_d     = '0;
         tt_gap_d        = '0;
         unsynced_drop_d = '0;
      end
   end

   // Output registers: load on acceptance, hold until the sink's ready is seen
   always_ff @(posedge clk_backend or posedge rst) begin
      if (rst) begin
         ev_valid            <= 1'b0;
         ev_data             <= '0;
         ev_period           <= '0;
         cmd_valid           <= 1'b0;
         cmd_data            <= '0;
         tt_update           <= 1'b0;
         tt_module           <= '0;
         frame_err_count     <= '0;
         tt_gap_count        <= '0;
         unsynced_drop_count <= '0;
      end else begin
         if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
         end
         if (ev_load) begin
            ev_valid  <= 1'b1;
            ev_data   <= in_data;
            ev_period <= rd_last;
         end
         if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
         end
         if (cmd_load) begin
            cmd_valid <= 1'b1;
            cmd_data  <= in_data;
         end
         tt_update <= tt_we;
         if (tt_we) begin
            tt_module <= word_module;
         end
         frame_err_count     <= frame_err_d;
         tt_gap_count        <= tt_gap_d;
         unsynced_drop_count <= unsynced_drop_d;
      end
   end

endmodule
